// File: rtl/dbg_gpr_access.sv
// Debug-side master for the register file's JTAG port: halts the core, performs one
// GPR read or write, and returns the result over a response handshake.
module dbg_gpr_access #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              halt_req_o,
    input  logic              halted_i,
    output logic              jtag_we_o,
    output logic [ADDR_W-1:0] jtag_addr_o,
    output logic [DATA_W-1:0] jtag_data_o,
    input  logic [DATA_W-1:0] jtag_data_i,
    output logic              busy_o
);
    localparam int unsigned CNT_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_HALT, S_ACCESS, S_RESP} state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              halt_req_q, halt_req_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              in_access;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        halt_req_d  = halt_req_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    write_d    = cmd_write_i;
                    addr_d     = cmd_addr_i;
                    wdata_d    = cmd_wdata_i;
                    cnt_d      = '0;
                    halt_req_d = 1'b1;
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    state_d    = S_HALT;
                end
            end
            S_HALT: begin
                if (halted_i) begin
                    state_d = S_ACCESS;
                end else if (cnt_q == CNT_LAST) begin
                    err_d       = 1'b1;
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACCESS: begin
                // Halt lost during the access cycle aborts; the write was already gated off.
                rsp_valid_d = 1'b1;
                err_d       = ~halted_i;
                rdata_d     = (halted_i && !write_q) ? jtag_data_i : '0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    halt_req_d  = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            halt_req_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            halt_req_q  <= halt_req_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Write enable is qualified by the live halted_i so it can never collide with the core.
    assign in_access   = (state_q == S_ACCESS);
    assign jtag_we_o   = in_access & write_q & halted_i & (addr_q != '0);
    assign jtag_addr_o = in_access ? addr_q : '0;
    assign jtag_data_o = jtag_we_o ? wdata_q : '0;

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign halt_req_o  = halt_req_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
endmodule

// File: tb/tb_dbg_gpr_access.sv
// Bench for dbg_gpr_access: two instances (default and short halt timeout) share stimulus
// through a select, checked against a transaction-level model of the access rules.
module tb_dbg_gpr_access;
    localparam int TO_A = 255;
    localparam int TO_B = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        cmd_valid, cmd_write, rsp_ready, halted;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;

    logic        a_cmd_ready, a_rsp_valid, a_rsp_err, a_halt_req, a_we, a_busy;
    logic [31:0] a_rsp_rdata, a_data, a_rd;
    logic [4:0]  a_addr;
    logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_halt_req, b_we, b_busy;
    logic [31:0] b_rsp_rdata, b_data, b_rd;
    logic [4:0]  b_addr;

    logic [31:0] regs  [32];
    logic [31:0] model [32];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dbg_gpr_access #(.ADDR_W(5), .DATA_W(32), .HALT_TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid & ~sel), .cmd_ready_o(a_cmd_ready),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err),
        .halt_req_o(a_halt_req), .halted_i(halted),
        .jtag_we_o(a_we), .jtag_addr_o(a_addr), .jtag_data_o(a_data),
        .jtag_data_i(a_rd), .busy_o(a_busy)
    );

    dbg_gpr_access #(.ADDR_W(5), .DATA_W(32), .HALT_TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid & sel), .cmd_ready_o(b_cmd_ready),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
        .halt_req_o(b_halt_req), .halted_i(halted),
        .jtag_we_o(b_we), .jtag_addr_o(b_addr), .jtag_data_o(b_data),
        .jtag_data_i(b_rd), .busy_o(b_busy)
    );

    // Register file environment: combinational read, x0 reads zero.
    assign a_rd = (a_addr == 5'd0) ? 32'd0 : regs[a_addr];
    assign b_rd = (b_addr == 5'd0) ? 32'd0 : regs[b_addr];
    always @(posedge clk) begin
        if (a_we) regs[a_addr] <= a_data;
        if (b_we) regs[b_addr] <= b_data;
    end

    wire        cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
    wire        rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    wire        rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    wire [31:0] rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    wire        halt_req  = sel ? b_halt_req  : a_halt_req;
    wire        busy      = sel ? b_busy      : a_busy;
    wire        we        = sel ? b_we        : a_we;
    wire [4:0]  jaddr     = sel ? b_addr      : a_addr;
    wire [31:0] jdata     = sel ? b_data      : a_data;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One command: halted_i low for hdelay HALT cycles, optionally dropped in the access
    // cycle, response held off for stall cycles.
    task automatic run_txn(input bit s, input bit w, input logic [4:0] a, input logic [31:0] d,
                           input int hdelay, input bit drop, input int stall);
        int          to_cyc, rsp_cyc, acc_cyc, we_cnt, we_cyc, c;
        bit          timed_out, exp_err, exp_we, got;
        logic [31:0] exp_rdata, we_data;
        to_cyc    = s ? TO_B : TO_A;
        timed_out = (hdelay >= to_cyc);
        exp_err   = timed_out || drop;
        exp_we    = !exp_err && w && (a != 5'd0);
        exp_rdata = (!exp_err && !w) ? model[a] : 32'd0;
        rsp_cyc   = timed_out ? to_cyc + 1 : hdelay + 3;
        acc_cyc   = timed_out ? -1 : hdelay + 2;

        @(negedge clk);
        sel = s; cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        halted = 1'b0; rsp_ready = 1'b0;
        #1 check_eq("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        we_cnt = 0; we_cyc = 0; we_data = 0; got = 0; c = 0;
        while (!got && c < 400) begin
            @(negedge clk);
            c++;
            cmd_valid = 1'b0;
            halted = (c > hdelay) && !(drop && c == acc_cyc);
            #1;
            if (rsp_valid) begin
                got = 1;
            end else begin
                check_eq("halt_req_busy", halt_req, 1);
                check_eq("busy", busy, 1);
                check_eq("cmd_ready_busy", cmd_ready, 0);
                check_eq("jtag_addr", jaddr, (c == acc_cyc) ? a : 5'd0);
                if (we) begin
                    we_cnt++; we_cyc = c; we_data = jdata;
                end else begin
                    check_eq("jtag_data_idle", jdata, 0);
                end
            end
        end
        check_eq("rsp_seen", got, 1);
        check_eq("rsp_cycle", c, rsp_cyc);
        check_eq("we_count", we_cnt, exp_we ? 1 : 0);
        if (exp_we) begin
            check_eq("we_cycle", we_cyc, acc_cyc);
            check_eq("we_data", we_data, d);
            model[a] = d;
        end
        for (int k = 0; k <= stall; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            check_eq("rsp_valid", rsp_valid, 1);
            check_eq("rsp_err", rsp_err, exp_err);
            check_eq("rsp_rdata", rsp_rdata, exp_rdata);
            check_eq("halt_req_resp", halt_req, 1);
            check_eq("cmd_ready_resp", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check_eq("rsp_valid_done", rsp_valid, 0);
        check_eq("halt_req_done", halt_req, 0);
        check_eq("cmd_ready_done", cmd_ready, 1);
        check_eq("busy_done", busy, 0);
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; rsp_ready = 1'b0; halted = 1'b0;
        for (int i = 0; i < 32; i++) begin
            regs[i]  = (i == 0) ? 32'd0 : $urandom;
            model[i] = regs[i];
        end
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_eq("rst_cmd_ready", cmd_ready, 1);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_halt_req", halt_req, 0);
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_rsp_rdata", rsp_rdata, 0);
            check_eq("rst_we", we, 0);
        end
        sel = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_txn(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        model[7] = 32'h12345678;
        regs[7]  = 32'h12345678;
        run_txn(0, 0, 5'd7, 32'h0, 0, 0, 0);
        run_txn(0, 0, 5'd5, 32'h0, 0, 0, 1);
        run_txn(0, 1, 5'd9, 32'hA5A5_0001, 10, 0, 0);
        run_txn(1, 1, 5'd3, 32'h1111_2222, 100, 0, 0);
        run_txn(1, 1, 5'd0, 32'hCAFE_F00D, 0, 0, 5);
        run_txn(1, 0, 5'd0, 32'h0, 7, 0, 0);
        run_txn(0, 1, 5'd4, 32'h4444_4444, 0, 1, 2);
        run_txn(0, 0, 5'd4, 32'h0, 0, 0, 0);

        @(negedge clk);
        sel = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd3; halted = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_eq("pre_rst_halt_req", halt_req, 1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_halt_req", halt_req, 0);
        check_eq("mid_rst_rsp_valid", rsp_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_we", we, 0);
        @(negedge clk);
        rst = 1'b1;
        run_txn(0, 0, 5'd1, 32'h0, 0, 0, 0);

        run_txn(0, 0, 5'd2, 32'h0, 260, 0, 0);

        for (int n = 0; n < 40; n++) begin
            bit          rs, rw, rdrop;
            logic [4:0]  ra;
            logic [31:0] rd;
            int          rh;
            rs    = ($urandom_range(0, 3) == 0);
            rw    = $urandom_range(0, 1);
            ra    = 5'($urandom_range(0, 31));
            rd    = $urandom;
            rh    = rs ? $urandom_range(0, 12) : $urandom_range(0, 6);
            rdrop = ($urandom_range(0, 7) == 0);
            run_txn(rs, rw, ra, rd, rh, rdrop, $urandom_range(0, 3));
        end

        for (int i = 1; i < 32; i++) begin
            check_eq("final_regs", regs[i], model[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
